// File: rtl/fx_regbank_if.sv
// fx bus port bundle: one write and one read channel, registered read data.
interface fx_regbank_if;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    modport master (
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fx_q
    );

    modport slave (
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fx_q
    );
endinterface

// File: rtl/fx_regbank.sv
// Parametrised 8-bit register bank on the fx bus: shadowed RW config with atomic
// commit through CTRL, read-only status slices and sticky write-1-to-clear status.
module fx_regbank #(
    parameter int          NREG        = 16,
    parameter logic [15:0] REG_BASE    = 16'h0080,
    parameter logic [7:0]  RST_BASE    = 8'h80,
    parameter logic [63:0] RO_MASK     = 64'h0,
    parameter logic [63:0] STICKY_MASK = 64'h0
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [5:0]        dev_id,
    fx_regbank_if.slave       bus,
    input  logic [NREG*8-1:0] sts_in,
    output logic [NREG*8-1:0] cfg_out,
    output logic              cfg_upd
);

    // Offsets are widened by one bit so REG_BASE+NREG cannot wrap.
    localparam logic [16:0] CTRL_OFF = 17'(REG_BASE) + 17'(NREG);

    logic        wsel;
    logic        rsel;
    logic [16:0] woff;
    logic [16:0] roff;
    logic        commit;
    logic [NREG-1:0] rw_wr;
    logic [7:0]  rd_val [NREG];

    logic        pending_q;
    logic        pending_d;
    logic        cfg_upd_q;
    logic [7:0]  fx_q_q;
    logic [7:0]  fx_q_d;

    logic        unused_sts;

    assign wsel   = (bus.fx_waddr[21:16] == dev_id);
    assign rsel   = (bus.fx_raddr[21:16] == dev_id);
    assign woff   = {1'b0, bus.fx_waddr[15:0]};
    assign roff   = {1'b0, bus.fx_raddr[15:0]};
    assign commit = bus.fx_wr && wsel && (woff == CTRL_OFF) && bus.fx_data[0];

    // RW slices of sts_in are intentionally ignored.
    assign unused_sts = ^sts_in;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [16:0] REG_OFF = 17'(REG_BASE) + 17'(gi);
            localparam logic [7:0]  RST_VAL = RST_BASE + 8'(gi);

            if (RO_MASK[gi]) begin : g_ro
                assign rd_val[gi]           = sts_in[gi*8 +: 8];
                assign cfg_out[gi*8 +: 8]   = 8'h00;
                assign rw_wr[gi]            = 1'b0;
            end else if (STICKY_MASK[gi]) begin : g_sticky
                logic       wr_hit;
                logic [7:0] wclr;
                logic [7:0] sticky_q;
                logic [7:0] sticky_d;

                assign wr_hit   = bus.fx_wr && wsel && (woff == REG_OFF);
                assign wclr     = wr_hit ? bus.fx_data : 8'h00;
                // Set is OR-ed after the clear so a same-cycle set wins.
                assign sticky_d = (sticky_q & ~wclr) | sts_in[gi*8 +: 8];

                always_ff @(posedge clk_sys or negedge rst_n) begin
                    if (!rst_n) begin
                        sticky_q <= 8'h00;
                    end else begin
                        sticky_q <= sticky_d;
                    end
                end

                assign rd_val[gi]         = sticky_q;
                assign cfg_out[gi*8 +: 8] = 8'h00;
                assign rw_wr[gi]          = 1'b0;
            end else begin : g_rw
                logic       wr_hit;
                logic [7:0] shadow_q;
                logic [7:0] shadow_d;
                logic [7:0] active_q;
                logic [7:0] active_d;

                assign wr_hit   = bus.fx_wr && wsel && (woff == REG_OFF);
                assign shadow_d = wr_hit ? bus.fx_data : shadow_q;
                assign active_d = commit ? shadow_q : active_q;

                always_ff @(posedge clk_sys or negedge rst_n) begin
                    if (!rst_n) begin
                        shadow_q <= RST_VAL;
                        active_q <= RST_VAL;
                    end else begin
                        shadow_q <= shadow_d;
                        active_q <= active_d;
                    end
                end

                assign rd_val[gi]         = shadow_q;
                assign cfg_out[gi*8 +: 8] = active_q;
                assign rw_wr[gi]          = wr_hit;
            end
        end
    endgenerate

    // Only one write per cycle, so a register write and a commit never coincide.
    always_comb begin
        pending_d = pending_q;
        if (|rw_wr) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        fx_q_d = 8'h00;
        if (bus.fx_rd && rsel) begin
            if (roff == 17'd0) begin
                fx_q_d = {2'b00, dev_id};
            end else if (roff == CTRL_OFF) begin
                fx_q_d = {7'b0, pending_q};
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    if (roff == 17'(REG_BASE) + 17'(i)) begin
                        fx_q_d = rd_val[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            cfg_upd_q <= 1'b0;
            fx_q_q    <= 8'h00;
        end else begin
            pending_q <= pending_d;
            cfg_upd_q <= commit;
            fx_q_q    <= fx_q_d;
        end
    end

    assign bus.fx_q = fx_q_q;
    assign cfg_upd  = cfg_upd_q;

endmodule

// File: tb/tb_fx_regbank.sv
// Self-checking bench for fx_regbank: directed scenarios plus randomized traffic
// against an array-based model of the register map.
module tb_fx_regbank;

    localparam int          NREG = 16;
    localparam logic [5:0]  DEV  = 6'h2A;
    localparam logic [15:0] CTRL = 16'h0090;

    logic               clk_sys = 1'b0;
    logic               rst_n   = 1'b0;
    logic [5:0]         dev_id;
    logic [NREG*8-1:0]  sts_in;
    logic [NREG*8-1:0]  cfg_out;
    logic               cfg_upd;

    fx_regbank_if bus();

    fx_regbank #(
        .NREG        (NREG),
        .REG_BASE    (16'h0080),
        .RST_BASE    (8'h80),
        .RO_MASK     (64'h10),
        .STICKY_MASK (64'h20)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .dev_id  (dev_id),
        .bus     (bus.slave),
        .sts_in  (sts_in),
        .cfg_out (cfg_out),
        .cfg_upd (cfg_upd)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // Model: register 4 is RO status, register 5 sticky, the rest RW.
    logic [7:0] m_shadow [NREG];
    logic [7:0] m_active [NREG];
    logic [7:0] m_sticky;
    logic [7:0] m_sts4;
    logic       m_pending;

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_shadow[i] = 8'(8'h80 + i);
            m_active[i] = 8'(8'h80 + i);
        end
        m_sticky  = 8'h00;
        m_pending = 1'b0;
    endfunction

    function automatic logic [NREG*8-1:0] model_cfg();
        logic [NREG*8-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i != 4 && i != 5) v[i*8 +: 8] = m_active[i];
        end
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic rd, input logic [21:0] ra);
        int idx;
        if (!rd || ra[21:16] != dev_id) return 8'h00;
        if (ra[15:0] == 16'h0000) return {2'b00, dev_id};
        if (ra[15:0] == CTRL) return {7'b0, m_pending};
        if (ra[15:0] >= 16'h0080 && ra[15:0] < CTRL) begin
            idx = int'(ra[15:0]) - 'h80;
            if (idx == 4) return m_sts4;
            if (idx == 5) return m_sticky;
            return m_shadow[idx];
        end
        return 8'h00;
    endfunction

    function automatic logic [21:0] fa(input logic [15:0] off);
        return {DEV, off};
    endfunction

    // One bus cycle: drive at negedge, advance the model, observe at the next negedge.
    task automatic step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [21:0] ra,
                        input logic [7:0] s4, input logic [7:0] s5,
                        output logic [7:0] q, output logic [7:0] q_exp,
                        output logic upd, output logic upd_exp);
        logic [NREG*8-1:0] noise;
        int idx;
        @(negedge clk_sys);
        noise = {$urandom, $urandom, $urandom, $urandom};
        noise[32 +: 8] = s4;
        noise[40 +: 8] = s5;
        sts_in = noise;
        m_sts4 = s4;
        bus.fx_wr    = wr;
        bus.fx_waddr = wa;
        bus.fx_data  = wd;
        bus.fx_rd    = rd;
        bus.fx_raddr = ra;
        q_exp   = model_read(rd, ra);
        upd_exp = 1'b0;
        if (wr && wa[21:16] == dev_id) begin
            if (wa[15:0] == CTRL) begin
                if (wd[0]) begin
                    for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
                    m_pending = 1'b0;
                    upd_exp   = 1'b1;
                end
            end else if (wa[15:0] >= 16'h0080 && wa[15:0] < CTRL) begin
                idx = int'(wa[15:0]) - 'h80;
                if (idx == 5) begin
                    m_sticky = m_sticky & ~wd;
                end else if (idx != 4) begin
                    m_shadow[idx] = wd;
                    m_pending     = 1'b1;
                end
            end
        end
        m_sticky = m_sticky | s5;
        @(negedge clk_sys);
        q   = bus.fx_q;
        upd = cfg_upd;
        bus.fx_wr = 1'b0;
        bus.fx_rd = 1'b0;
        sts_in[40 +: 8] = 8'h00;
    endtask

    logic [7:0] q, qe;
    logic       u, ue;

    task automatic test_reset();
        rst_n = 1'b0;
        dev_id = DEV;
        sts_in = '0;
        bus.fx_wr = 1'b0; bus.fx_rd = 1'b0;
        bus.fx_waddr = '0; bus.fx_raddr = '0; bus.fx_data = '0;
        model_reset();
        #12;
        checks++; if (cfg_out[24 +: 8] !== 8'h83) begin errors++; $display("FAIL reset_cfg3: got %h want 83", cfg_out[24 +: 8]); end
        checks++; if (cfg_out !== model_cfg()) begin errors++; $display("FAIL reset_cfg: got %h want %h", cfg_out, model_cfg()); end
        checks++; if (cfg_upd !== 1'b0 || bus.fx_q !== 8'h00) begin errors++; $display("FAIL reset_out: got upd=%b q=%h want 0/00", cfg_upd, bus.fx_q); end
        @(negedge clk_sys);
        rst_n = 1'b1;
        step(0, 0, 0, 1, fa(16'h0080), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL reset_rd80: got %h want 80", q); end
        step(0, 0, 0, 1, fa(16'h008F), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h8F) begin errors++; $display("FAIL reset_rd8f: got %h want 8f", q); end
        step(0, 0, 0, 1, fa(16'h0000), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h2A) begin errors++; $display("FAIL reset_devid: got %h want 2a", q); end
        step(0, 0, 0, 1, fa(CTRL), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", q); end
    endtask

    task automatic test_rw_commit();
        step(1, fa(16'h0082), 8'h5A, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0082), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL rw_readback: got %h want 5a", q); end
        checks++; if (cfg_out[16 +: 8] !== 8'h82) begin errors++; $display("FAIL rw_active_hold: got %h want 82", cfg_out[16 +: 8]); end
        step(0, 0, 0, 1, fa(CTRL), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL rw_pending: got %h want 01", q); end
        step(1, fa(CTRL), 8'h01, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (u !== 1'b1) begin errors++; $display("FAIL commit_pulse: got %b want 1", u); end
        checks++; if (cfg_out[16 +: 8] !== 8'h5A) begin errors++; $display("FAIL commit_cfg2: got %h want 5a", cfg_out[16 +: 8]); end
        @(negedge clk_sys);
        checks++; if (cfg_upd !== 1'b0) begin errors++; $display("FAIL commit_one_cycle: got %b want 0", cfg_upd); end
        step(0, 0, 0, 1, fa(CTRL), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL commit_clr_pending: got %h want 00", q); end
        step(1, fa(16'h0082), 8'h11, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        step(1, fa(CTRL), 8'hFE, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (u !== 1'b0 || cfg_out[16 +: 8] !== 8'h5A) begin errors++; $display("FAIL ctrl_noop: got upd=%b cfg2=%h want 0/5a", u, cfg_out[16 +: 8]); end
        step(1, fa(CTRL), 8'h01, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (cfg_out[16 +: 8] !== 8'h11) begin errors++; $display("FAIL commit2_cfg2: got %h want 11", cfg_out[16 +: 8]); end
        step(1, fa(CTRL), 8'h01, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (u !== 1'b1) begin errors++; $display("FAIL commit_nopend: got %b want 1", u); end
    endtask

    task automatic test_dev_id();
        step(1, {DEV ^ 6'h01, 16'h0081}, 8'hFF, 0, 0, 8'h00, 8'h00, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0081), 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL devid_wr_ignored: got %h want 81", q); end
        step(0, 0, 0, 1, {DEV ^ 6'h10, 16'h0081}, 8'h00, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL devid_rd_zero: got %h want 00", q); end
    endtask

    task automatic test_ro();
        step(0, 0, 0, 1, fa(16'h0084), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL ro_read: got %h want 3c", q); end
        step(1, fa(16'h0084), 8'h00, 0, 0, 8'h3C, 8'h00, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0084), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h3C || cfg_out[32 +: 8] !== 8'h00) begin errors++; $display("FAIL ro_write_ignored: got %h cfg4=%h want 3c/00", q, cfg_out[32 +: 8]); end
    endtask

    task automatic test_sticky();
        step(0, 0, 0, 0, 0, 8'h3C, 8'h01, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0085), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL sticky_set: got %h want 01", q); end
        step(1, fa(16'h0085), 8'h01, 0, 0, 8'h3C, 8'h00, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0085), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL sticky_w1c: got %h want 00", q); end
        step(1, fa(16'h0085), 8'h01, 0, 0, 8'h3C, 8'h01, q, qe, u, ue);
        step(0, 0, 0, 1, fa(16'h0085), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL sticky_set_wins: got %h want 01", q); end
        step(1, fa(16'h0085), 8'hFF, 0, 0, 8'h3C, 8'h00, q, qe, u, ue);
    endtask

    task automatic test_unmapped();
        step(0, 0, 0, 1, fa(16'h0200), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL unmapped_rd: got %h want 00", q); end
        step(0, 0, 0, 1, fa(16'h0091), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL past_ctrl_rd: got %h want 00", q); end
        step(0, 0, 0, 1, fa(16'h007F), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL below_base_rd: got %h want 00", q); end
        step(1, fa(16'h0200), 8'hFF, 0, 0, 8'h3C, 8'h00, q, qe, u, ue);
        step(0, 0, 0, 1, fa(CTRL), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL unmapped_wr_pending: got %h want 00", q); end
    endtask

    task automatic test_same_cycle();
        step(1, fa(16'h0083), 8'hC3, 1, fa(16'h0083), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h83) begin errors++; $display("FAIL rw_same_cycle: got %h want 83", q); end
        step(0, 0, 0, 1, fa(16'h0083), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL rw_after_write: got %h want c3", q); end
    endtask

    task automatic test_reset_pending();
        step(1, fa(16'h0086), 8'h77, 0, 0, 8'h3C, 8'h00, q, qe, u, ue);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (cfg_out[16 +: 8] !== 8'h82 || cfg_out[48 +: 8] !== 8'h86) begin errors++; $display("FAIL async_rst_cfg: got cfg2=%h cfg6=%h want 82/86", cfg_out[16 +: 8], cfg_out[48 +: 8]); end
        @(negedge clk_sys);
        rst_n = 1'b1;
        step(0, 0, 0, 1, fa(16'h0086), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h86) begin errors++; $display("FAIL rst_shadow_lost: got %h want 86", q); end
        step(0, 0, 0, 1, fa(CTRL), 8'h3C, 8'h00, q, qe, u, ue);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want 00", q); end
    endtask

    task automatic test_random();
        logic        wr, rd;
        logic [21:0] wa, ra;
        logic [15:0] off;
        logic [7:0]  wd, s4, s5;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 5))
                    0:       off = 16'h0000;
                    4:       off = 16'h0200;
                    5:       off = 16'($urandom);
                    default: off = 16'(16'h0080 + $urandom_range(0, 16));
                endcase
                if (k == 0) wa = {($urandom_range(0, 9) == 0) ? 6'($urandom) : DEV, off};
                else        ra = {($urandom_range(0, 9) == 0) ? 6'($urandom) : DEV, off};
            end
            wr = 1'($urandom);
            rd = 1'($urandom);
            wd = 8'($urandom);
            s4 = 8'($urandom);
            s5 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(wr, wa, wd, rd, ra, s4, s5, q, qe, u, ue);
            checks++; if (q !== qe) begin errors++; $display("FAIL rand_q[%0d]: got %h want %h", n, q, qe); end
            checks++; if (u !== ue) begin errors++; $display("FAIL rand_upd[%0d]: got %b want %b", n, u, ue); end
            checks++; if (cfg_out !== model_cfg()) begin errors++; $display("FAIL rand_cfg[%0d]: got %h want %h", n, cfg_out, model_cfg()); end
        end
    endtask

    initial begin
        test_reset();
        test_rw_commit();
        test_dev_id();
        test_ro();
        test_sticky();
        test_unmapped();
        test_same_cycle();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
